// File: rtl/mult_share_if.sv
// mult_share_if: bundle between the operand requesters, the response consumer,
// the shared multiplier and mult_share_ctrl.
//   req_valid/req_x/req_y/req_ready : NUM_REQ request channels (8-bit signed operands,
//                                     requester i at bits [8i+7:8i])
//   mult_x/mult_y/mult_out          : operands to / product from the combinational multiplier
//   resp_valid/resp_data/resp_id/resp_ready : tagged 16-bit product response
// Handshake rule for every valid/ready pair: a transfer happens on a rising clk edge
// where both valid and ready are high; a source keeps valid and its payload stable
// until that transfer, and ready never depends on a transfer in the same cycle.
// modport slave is the controller's view; modport master is the environment's view.
interface mult_share_if #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_x;
  logic [8*NUM_REQ-1:0] req_y;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           mult_x;
  logic [7:0]           mult_y;
  logic [15:0]          mult_out;
  logic                 resp_valid;
  logic [15:0]          resp_data;
  logic [ID_W-1:0]      resp_id;
  logic                 resp_ready;

  modport slave (
    input  req_valid, req_x, req_y, mult_out, resp_ready,
    output req_ready, mult_x, mult_y, resp_valid, resp_data, resp_id
  );

  modport master (
    output req_valid, req_x, req_y, mult_out, resp_ready,
    input  req_ready, mult_x, mult_y, resp_valid, resp_data, resp_id
  );
endinterface

// File: rtl/mult_share_ctrl.sv
// mult_share_ctrl: shares one combinational 8x8 signed multiplier among NUM_REQ
// requesters with round-robin arbitration. One operation runs at a time through
// IDLE (arbitrate/accept) -> CALC (operands on the multiplier) -> RESP (hold the
// registered, tagged product until the consumer takes it).
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   bus        mult_share_if.slave (requests, multiplier operands/product, response)
//   busy       high whenever the FSM is not in IDLE
//   state_dbg  current FSM state (IDLE=0, CALC=1, RESP=2)
module mult_share_ctrl #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  mult_share_if.slave        bus,
  output logic               busy,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t               state;
  logic [ID_W-1:0]      rr_ptr;
  logic [ID_W-1:0]      op_id;
  logic [7:0]           op_x;
  logic [7:0]           op_y;

  logic                 any_valid;
  logic                 found_hi;
  logic [ID_W-1:0]      grant_hi;
  logic [ID_W-1:0]      grant_lo;
  logic [ID_W-1:0]      grant;
  logic [NUM_REQ-1:0]   onehot;
  logic [8*NUM_REQ-1:0] shift_x;
  logic [8*NUM_REQ-1:0] shift_y;
  logic [7:0]           sel_x;
  logic [7:0]           sel_y;

  // Round-robin search: the lowest valid index at or above rr_ptr wins; if none
  // exists the search wraps, which is simply the lowest valid index overall.
  always_comb begin
    any_valid = 1'b0;
    found_hi  = 1'b0;
    grant_hi  = '0;
    grant_lo  = '0;
    onehot    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      onehot = NUM_REQ'(1) << i;
      if (|(bus.req_valid & onehot)) begin
        if (!found_hi && (ID_W'(i) >= rr_ptr)) begin
          found_hi = 1'b1;
          grant_hi = ID_W'(i);
        end
        if (!any_valid) begin
          any_valid = 1'b1;
          grant_lo  = ID_W'(i);
        end
      end
    end
    grant = found_hi ? grant_hi : grant_lo;
  end

  // Operand mux for the granted requester.
  always_comb begin
    shift_x = '0;
    shift_y = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant == ID_W'(i)) begin
        shift_x = bus.req_x >> (8 * i);
        shift_y = bus.req_y >> (8 * i);
      end
    end
    sel_x = shift_x[7:0];
    sel_y = shift_y[7:0];
  end

  // Ready is gated by rst_n so nothing can be accepted while reset is held.
  always_comb begin
    bus.req_ready = '0;
    if (rst_n && (state == IDLE) && any_valid) begin
      bus.req_ready = NUM_REQ'(1) << grant;
    end
  end

  // Operand registers drive the multiplier directly, so the operands stay put
  // through CALC and RESP and keep their last value while IDLE.
  assign bus.mult_x = op_x;
  assign bus.mult_y = op_y;
  assign busy       = (state != IDLE);
  assign state_dbg  = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      rr_ptr         <= '0;
      op_x           <= '0;
      op_y           <= '0;
      op_id          <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_data  <= '0;
      bus.resp_id    <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Ready is asserted for the grant whenever any request is valid,
          // so any_valid alone means a transfer happens on this edge.
          if (any_valid) begin
            op_x  <= sel_x;
            op_y  <= sel_y;
            op_id <= grant;
            state <= CALC;
          end
        end
        CALC: begin
          bus.resp_data  <= bus.mult_out;
          bus.resp_id    <= op_id;
          bus.resp_valid <= 1'b1;
          state          <= RESP;
        end
        RESP: begin
          if (bus.resp_ready) begin
            bus.resp_valid <= 1'b0;
            rr_ptr         <= (op_id == ID_W'(NUM_REQ - 1)) ? '0 : op_id + ID_W'(1);
            state          <= IDLE;
          end
        end
        default: begin
          state          <= IDLE;
          bus.resp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_share_ctrl.sv
// tb_mult_share_ctrl: directed scenarios followed by randomized traffic for
// mult_share_ctrl, checked every cycle against a transaction-level model.
module tb_mult_share_ctrl;
  localparam int NUM_REQ = 2;
  localparam int ID_W    = 2;
  localparam int XW      = 8 * NUM_REQ;
  localparam int EW      = 16 + ID_W;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       busy;
  logic [1:0] state_dbg;

  always #5 clk = ~clk;

  mult_share_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) ifc ();

  mult_share_ctrl #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (ifc.slave),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // Combinational signed 8x8 multiplier shared by the controller.
  always_comb
    ifc.mult_out = 16'($signed({{8{ifc.mult_x[7]}}, ifc.mult_x}) *
                       $signed({{8{ifc.mult_y[7]}}, ifc.mult_y}));

  // ---------------- check bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Round-robin rule: first valid index searching ptr, ptr+1, ... mod NUM_REQ.
  function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int ptr);
    int idx;
    rr_pick = -1;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (ptr + k) % NUM_REQ;
      if (v[idx]) rr_pick = idx;
    end
  endfunction

  function automatic logic [15:0] prod(input logic [7:0] a, input logic [7:0] b);
    int sa;
    int sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    return 16'(sa * sb);
  endfunction

  // m_phase counts progress of the current transaction: 0 free, 1 product being
  // formed, 2 response offered.
  logic [EW-1:0]   exp_q[$];
  bit              model_on = 1'b0;
  int              m_phase;
  int              m_rr;
  int              m_id;
  int              m_g;
  logic [7:0]      m_x;
  logic [7:0]      m_y;
  logic [15:0]     m_rdata;
  logic [ID_W-1:0] m_rid;

  always @(posedge clk) begin
    if (!rst_n) begin
      model_on = 1'b1;
      m_phase  = 0;
      m_rr     = 0;
      m_id     = 0;
      m_x      = '0;
      m_y      = '0;
      m_rdata  = '0;
      m_rid    = '0;
      exp_q.delete();
    end else if (model_on) begin
      case (m_phase)
        0: begin
          m_g = rr_pick(ifc.req_valid, m_rr);
          if (m_g >= 0) begin
            m_x  = ifc.req_x[8*m_g +: 8];
            m_y  = ifc.req_y[8*m_g +: 8];
            m_id = m_g;
            exp_q.push_back({ID_W'(m_g), prod(m_x, m_y)});
            m_phase = 1;
          end
        end
        1: begin
          {m_rid, m_rdata} = exp_q[0];
          m_phase = 2;
        end
        default: begin
          if (ifc.resp_ready) begin
            void'(exp_q.pop_front());
            m_rr    = (m_id + 1) % NUM_REQ;
            m_phase = 0;
          end
        end
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [NUM_REQ-1:0] c_ready;
  int                 c_g;

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (model_on) begin
        c_ready = '0;
        if (rst_n && m_phase == 0) begin
          c_g = rr_pick(ifc.req_valid, m_rr);
          if (c_g >= 0) c_ready = NUM_REQ'(1) << c_g;
        end
        check("req_ready",  32'(ifc.req_ready),  32'(c_ready));
        check("resp_valid", 32'(ifc.resp_valid), 32'(m_phase == 2));
        check("busy",       32'(busy),           32'(m_phase != 0));
        check("resp_data",  32'(ifc.resp_data),  32'(m_rdata));
        check("resp_id",    32'(ifc.resp_id),    32'(m_rid));
        check("mult_x",     32'(ifc.mult_x),     32'(m_x));
        check("mult_y",     32'(ifc.mult_y),     32'(m_y));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Present one request and hold it until granted; returns at the falling edge
  // after the accepting edge, with the request withdrawn.
  task automatic request(input int idx, input logic [7:0] x, input logic [7:0] y);
    int n;
    @(negedge clk);
    ifc.req_valid[idx]    = 1'b1;
    ifc.req_x[8*idx +: 8] = x;
    ifc.req_y[8*idx +: 8] = y;
    n = 0;
    #2;
    while (!ifc.req_ready[idx] && n < 20) begin
      @(negedge clk);
      #2;
      n++;
    end
    check($sformatf("grant_req%0d", idx), 32'(ifc.req_ready[idx]), 32'd1);
    @(negedge clk);
    ifc.req_valid[idx] = 1'b0;
  endtask

  // Wait (bounded) for the response following request(); latency is counted in
  // falling edges after the one where request() returned.
  task automatic wait_resp(input int id, input logic [15:0] d, input string nm);
    int n;
    n = 0;
    #2;
    while (!ifc.resp_valid && n < 10) begin
      @(negedge clk);
      #2;
      n++;
    end
    check({nm, "_seen"},    32'(ifc.resp_valid), 32'd1);
    check({nm, "_latency"}, 32'(n),              32'd1);
    check({nm, "_data"},    32'(ifc.resp_data),  32'(d));
    check({nm, "_id"},      32'(ifc.resp_id),    32'(id));
  endtask

  // ---------------- stimulus ----------------
  logic [ID_W-1:0]    ids [4];
  int                 k;
  bit [NUM_REQ-1:0]   pend;
  bit [NUM_REQ-1:0]   acc;

  initial begin
    ifc.req_valid  = '0;
    ifc.req_x      = '0;
    ifc.req_y      = '0;
    ifc.resp_ready = 1'b0;
    rst_n          = 1'b0;

    // Pin the model with hand-computed values.
    check("model_prod_min",  32'(prod(8'h80, 8'h80)), 32'h4000);
    check("model_prod_mix",  32'(prod(8'h7f, 8'h80)), 32'hC080);
    check("model_rr_wrap",   32'(rr_pick(2'b01, 1)),  32'd0);
    check("model_rr_ptr",    32'(rr_pick(2'b11, 1)),  32'd1);
    check("model_rr_none",   32'(rr_pick(2'b00, 0)),  32'hFFFF_FFFF);

    // Reset held while every input toggles.
    repeat (5) begin
      @(negedge clk);
      ifc.req_valid  = NUM_REQ'($urandom);
      ifc.req_x      = XW'($urandom);
      ifc.req_y      = XW'($urandom);
      ifc.resp_ready = 1'($urandom);
      #2;
      check("rst_resp_valid", 32'(ifc.resp_valid), 32'd0);
      check("rst_req_ready",  32'(ifc.req_ready),  32'd0);
      check("rst_busy",       32'(busy),           32'd0);
      check("rst_mult_x",     32'(ifc.mult_x),     32'd0);
      check("rst_resp_data",  32'(ifc.resp_data),  32'd0);
      check("rst_resp_id",    32'(ifc.resp_id),    32'd0);
    end
    @(negedge clk);
    rst_n          = 1'b1;
    ifc.req_valid  = '0;
    ifc.resp_ready = 1'b1;

    // Single requests at the operand extremes.
    request(0, 8'h80, 8'h80);
    wait_resp(0, 16'h4000, "neg_neg");
    request(1, 8'h7f, 8'h80);
    wait_resp(1, 16'hC080, "pos_neg");

    // Both requesters valid continuously: grants must alternate.
    @(negedge clk);
    ifc.req_x     = {8'd5, 8'hFD};
    ifc.req_y     = {8'hF0, 8'd11};
    ifc.req_valid = '1;
    k = 0;
    repeat (13) begin
      #2;
      if (ifc.resp_valid && k < 4) begin
        ids[k] = ifc.resp_id;
        k++;
      end
      @(negedge clk);
    end
    ifc.req_valid = '0;
    check("rr_count", 32'(k),      32'd4);
    check("rr_grant0", 32'(ids[0]), 32'd0);
    check("rr_grant1", 32'(ids[1]), 32'd1);
    check("rr_grant2", 32'(ids[2]), 32'd0);
    check("rr_grant3", 32'(ids[3]), 32'd1);
    repeat (3) @(negedge clk);

    // Consumer stall: response held, no new grant while another request waits.
    ifc.resp_ready = 1'b0;
    request(0, 8'd7, 8'hF7);
    wait_resp(0, 16'hFFC1, "stall");
    repeat (5) begin
      @(negedge clk);
      ifc.req_valid[1] = 1'b1;
      ifc.req_x[15:8]  = 8'd2;
      ifc.req_y[15:8]  = 8'd2;
      #2;
      check("stall_valid", 32'(ifc.resp_valid), 32'd1);
      check("stall_data",  32'(ifc.resp_data),  32'hFFC1);
      check("stall_id",    32'(ifc.resp_id),    32'd0);
      check("stall_ready", 32'(ifc.req_ready),  32'd0);
    end
    @(negedge clk);
    ifc.req_valid[1] = 1'b0;
    ifc.resp_ready   = 1'b1;
    #2;
    check("release_hold", 32'(ifc.resp_valid), 32'd1);
    @(negedge clk);
    #2;
    check("release_idle_busy",  32'(busy),           32'd0);
    check("release_idle_valid", 32'(ifc.resp_valid), 32'd0);

    // Reset while the product is being formed: that operation vanishes.
    request(0, 8'd9, 8'd9);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      #2;
      check("abort_no_resp", 32'(ifc.resp_valid), 32'd0);
      @(negedge clk);
    end
    request(1, 8'd3, 8'hFB);
    wait_resp(1, 16'hFFF1, "after_abort");

    // Randomized traffic; first stretch keeps resp_ready high, one reset mid-run.
    pend = '0;
    acc  = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (acc[i]) pend[i] = 1'b0;
        if (!pend[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            pend[i]             = 1'b1;
            ifc.req_x[8*i +: 8] = 8'($urandom);
            ifc.req_y[8*i +: 8] = 8'($urandom);
          end
        end else if ($urandom_range(0, 15) == 0) begin
          pend[i] = 1'b0;
        end
      end
      ifc.req_valid  = pend;
      ifc.resp_ready = (cyc < 100) ? 1'b1 : ($urandom_range(0, 3) != 0);
      rst_n          = (cyc != 250);
      #2;
      acc = ifc.req_ready;
    end
    @(negedge clk);
    ifc.req_valid  = '0;
    ifc.resp_ready = 1'b1;
    rst_n          = 1'b1;
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
